// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs: definitions shared by the pipeline control logic.
//   - Stall vector constants. Bit k of a stall vector holds buffer k:
//     bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
//     A buffer that sees its own bit set and the next bit clear inserts a
//     bubble downstream, so a vector of contiguous low ones freezes the front
//     of the pipe while the back drains.
//   - Controller state enum.
//   - Exception codes, including the ERET pseudo-code.
//   - Helper that selects the redirect PC for a flush.
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam int STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    // Load-use: hold PC and IF/ID, bubble into ID/EX.
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    // Multi-cycle EX op: hold everything up to ID/EX, bubble into EX/MEM.
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_WAIT = 2'd1,
        REFILL  = 2'd2
    } ctrl_state_t;

    // Exception codes as reported by MEM/CP0.
    localparam logic [4:0] EXC_CODE_INT     = 5'h00;
    localparam logic [4:0] EXC_CODE_ADEL    = 5'h04;
    localparam logic [4:0] EXC_CODE_ADES    = 5'h05;
    localparam logic [4:0] EXC_CODE_SYSCALL = 5'h08;
    localparam logic [4:0] EXC_CODE_BREAK   = 5'h09;
    localparam logic [4:0] EXC_CODE_RI      = 5'h0A;
    localparam logic [4:0] EXC_CODE_OV      = 5'h0C;
    localparam logic [4:0] EXC_CODE_ERET    = 5'h0E;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    // ERET returns to the saved EPC; every other code enters the handler.
    function automatic logic [31:0] redirect_pc(
        input logic [4:0]  excp_type,
        input logic [31:0] epc,
        input logic [4:0]  eret_code,
        input logic [31:0] exc_vector
    );
        return (excp_type == eret_code) ? epc : exc_vector;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk    in   clock
//   reset  in   synchronous active-high reset, clears the count
//   en     in   count this cycle
//   count  out  current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (en && (count_reg != CNT_MAX)) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl: central stall / flush controller for the 5-stage core.
//   clk           in   clock
//   reset         in   synchronous active-high reset
//   stallreq_id   in   ID load-use hazard request
//   ex_mc_start   in   EX starts a multi-cycle op (1-cycle pulse)
//   ex_mc_done    in   EX multi-cycle result ready (1-cycle pulse)
//   excp_valid    in   MEM-stage exception / ERET committed this cycle
//   excp_type     in   exception code (ERET_CODE means return to cp0_epc)
//   cp0_epc       in   EPC from CP0
//   stall_en      out  per-buffer hold vector (combinational)
//   flush         out  clear all buffers and load new_pc (combinational)
//   new_pc        out  redirect target, zero when flush is low
//   mc_timeout    out  sticky watchdog error, cleared only by reset
//   stall_cycles  out  saturating count of cycles with stall_en[0] set
//
// Priority each cycle: exception > multi-cycle stall > ID stall. The cycle
// after a flush (REFILL) ignores every request since it can only come from
// instructions that were just squashed.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter logic [4:0]  ERET_CODE  = EXC_CODE_ERET,
    parameter int          MC_TIMEOUT = 64,
    parameter int          CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallreq_id,
    input  logic              ex_mc_start,
    input  logic              ex_mc_done,
    input  logic              excp_valid,
    input  logic [4:0]        excp_type,
    input  logic [31:0]       cp0_epc,
    output logic [5:0]        stall_en,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_timeout,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Wide enough to hold MC_TIMEOUT itself.
    localparam int WD_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MC_TIMEOUT);

    ctrl_state_t        state_reg, state_next;
    logic [WD_W-1:0]    wd_cnt_reg, wd_cnt_next;
    logic               mc_timeout_reg, mc_timeout_next;

    // Ungated decode results; reset masking is applied on the way out.
    logic [STALL_W-1:0] stall_vec;
    logic               flush_raw;
    logic [31:0]        new_pc_raw;

    always_comb begin
        state_next      = state_reg;
        wd_cnt_next     = wd_cnt_reg;
        mc_timeout_next = mc_timeout_reg;
        stall_vec       = STALL_NONE;
        flush_raw       = 1'b0;
        new_pc_raw      = 32'h0;

        case (state_reg)
            IDLE: begin
                if (excp_valid) begin
                    flush_raw  = 1'b1;
                    new_pc_raw = redirect_pc(excp_type, cp0_epc, ERET_CODE, EXC_VECTOR);
                    state_next = REFILL;
                end else if (ex_mc_start && !ex_mc_done) begin
                    // Start and done together is a single-cycle op: no stall,
                    // and it falls through to the ID check below.
                    stall_vec   = STALL_EX;
                    state_next  = MC_WAIT;
                    wd_cnt_next = WD_W'(1);
                end else if (stallreq_id) begin
                    stall_vec = STALL_ID;
                end
            end

            MC_WAIT: begin
                if (excp_valid) begin
                    // Abort the op; the EX unit result is discarded by the flush.
                    flush_raw  = 1'b1;
                    new_pc_raw = redirect_pc(excp_type, cp0_epc, ERET_CODE, EXC_VECTOR);
                    state_next = REFILL;
                end else if (ex_mc_done) begin
                    // Done wins over the watchdog if both land together.
                    stall_vec  = stallreq_id ? STALL_ID : STALL_NONE;
                    state_next = IDLE;
                end else if (wd_cnt_reg == WD_LIMIT) begin
                    // Give up: release the pipe and flag the error.
                    mc_timeout_next = 1'b1;
                    state_next      = IDLE;
                end else begin
                    stall_vec   = STALL_EX;
                    wd_cnt_next = wd_cnt_reg + WD_W'(1);
                end
            end

            REFILL: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wd_cnt_reg     <= '0;
            mc_timeout_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wd_cnt_reg     <= wd_cnt_next;
            mc_timeout_reg <= mc_timeout_next;
        end
    end

    // Combinational outputs are forced quiet while reset is asserted so a
    // reset mid-op never produces a stall or flush.
    generate
        for (genvar gi = 0; gi < STALL_W; gi++) begin : g_stall_gate
            assign stall_en[gi] = stall_vec[gi] & ~reset;
        end
        for (genvar gi = 0; gi < 32; gi++) begin : g_pc_gate
            assign new_pc[gi] = new_pc_raw[gi] & ~reset;
        end
    endgenerate

    assign flush      = flush_raw & ~reset;
    assign mc_timeout = mc_timeout_reg;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en[0]),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int T = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        sid = 1'b0, start = 1'b0, done = 1'b0, ev = 1'b0;
    logic [4:0]  et = 5'h0;
    logic [31:0] epc = 32'h0;

    logic [5:0]  stall_en, stall_en4;
    logic        flush, flush4;
    logic [31:0] new_pc, new_pc4;
    logic        mc_timeout, mc_timeout4;
    logic [15:0] stall_cycles;
    logic [3:0]  stall_cycles4;

    pipe_stall_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stallreq_id(sid), .ex_mc_start(start),
        .ex_mc_done(done), .excp_valid(ev), .excp_type(et), .cp0_epc(epc),
        .stall_en(stall_en), .flush(flush), .new_pc(new_pc),
        .mc_timeout(mc_timeout), .stall_cycles(stall_cycles)
    );

    pipe_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stallreq_id(sid), .ex_mc_start(start),
        .ex_mc_done(done), .excp_valid(ev), .excp_type(et), .cp0_epc(epc),
        .stall_en(stall_en4), .flush(flush4), .new_pc(new_pc4),
        .mc_timeout(mc_timeout4), .stall_cycles(stall_cycles4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: "busy" with the number of cycles since the op started,
    // a one-shot "just flushed" marker, and plain integer counters.
    bit m_busy, m_flushed, m_tout;
    int m_age, m_cnt16, m_cnt4;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;

    typedef struct {
        logic        sid, start, done, ev;
        logic [4:0]  et;
        logic [31:0] epc;
        logic [5:0]  x_stall;
        logic        x_flush;
        logic [31:0] x_pc;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_expect();
        e_stall = 6'b0; e_flush = 1'b0; e_pc = 32'h0;
        if (reset || m_flushed) begin
            // quiet
        end else if (ev) begin
            e_flush = 1'b1;
            e_pc    = (et == 5'h0E) ? epc : 32'h0000_0020;
        end else if (m_busy) begin
            if (done)            e_stall = sid ? 6'b000111 : 6'b0;
            else if (m_age == T) e_stall = 6'b0;
            else                 e_stall = 6'b001111;
        end else begin
            if (start && !done) e_stall = 6'b001111;
            else if (sid)       e_stall = 6'b000111;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_flushed = 0; m_tout = 0; m_age = 0; m_cnt16 = 0; m_cnt4 = 0;
            return;
        end
        if (e_stall[0]) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15)     m_cnt4++;
        end
        if (m_flushed) begin
            m_flushed = 0;
        end else if (ev) begin
            m_flushed = 1; m_busy = 0;
        end else if (m_busy) begin
            if (done) m_busy = 0;
            else if (m_age == T) begin m_busy = 0; m_tout = 1; end
            else m_age++;
        end else if (start && !done) begin
            m_busy = 1; m_age = 1;
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, print a line.
    task automatic cycle(input logic r, input logic s, input logic st, input logic d,
                         input logic e, input logic [4:0] t, input logic [31:0] p,
                         input string tag);
        @(posedge clk);
        #1;
        reset = r; sid = s; start = st; done = d; ev = e; et = t; epc = p;
        model_expect();
        #3;
        chk({tag, ".stall"}, 32'(stall_en), 32'(e_stall));
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
        chk({tag, ".pc"}, new_pc, e_pc);
        if (!r) begin
            chk({tag, ".cnt"}, 32'(stall_cycles), 32'(m_cnt16));
            chk({tag, ".cnt4"}, 32'(stall_cycles4), 32'(m_cnt4));
            chk({tag, ".tout"}, 32'(mc_timeout), 32'(m_tout));
        end
        $display("%s rst=%b sid=%b st=%b dn=%b ev=%b stall=%b flush=%b pc=%h cnt=%0d tout=%b",
                 tag, r, s, st, d, e, stall_en, flush, new_pc, stall_cycles, mc_timeout);
        model_step();
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, tag);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, "rst");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, "rst");
    endtask

    initial begin
        //            sid st dn ev  et     epc            stall      fl  pc
        tbl[0]  = '{1, 0, 0, 0, 5'h00, 32'h0,       6'b000111, 0, 32'h0};
        tbl[1]  = '{0, 0, 0, 0, 5'h00, 32'h0,       6'b000000, 0, 32'h0};
        tbl[2]  = '{0, 1, 0, 0, 5'h00, 32'h0,       6'b001111, 0, 32'h0};
        tbl[3]  = '{0, 0, 0, 0, 5'h00, 32'h0,       6'b001111, 0, 32'h0};
        tbl[4]  = '{1, 0, 0, 0, 5'h00, 32'h0,       6'b001111, 0, 32'h0};
        tbl[5]  = '{1, 0, 1, 0, 5'h00, 32'h0,       6'b000111, 0, 32'h0};
        tbl[6]  = '{0, 0, 0, 0, 5'h00, 32'h0,       6'b000000, 0, 32'h0};
        tbl[7]  = '{0, 1, 1, 0, 5'h00, 32'h0,       6'b000000, 0, 32'h0};
        tbl[8]  = '{1, 0, 0, 0, 5'h00, 32'h0,       6'b000111, 0, 32'h0};
        tbl[9]  = '{0, 1, 0, 0, 5'h00, 32'h0,       6'b001111, 0, 32'h0};
        tbl[10] = '{0, 0, 0, 1, 5'h0E, 32'h1234,    6'b000000, 1, 32'h0000_1234};
        tbl[11] = '{1, 1, 0, 1, 5'h0C, 32'h5555,    6'b000000, 0, 32'h0};
        tbl[12] = '{0, 0, 0, 0, 5'h00, 32'h0,       6'b000000, 0, 32'h0};
        tbl[13] = '{0, 0, 0, 1, 5'h0C, 32'h9999,    6'b000000, 1, 32'h0000_0020};
        tbl[14] = '{0, 0, 0, 0, 5'h00, 32'h0,       6'b000000, 0, 32'h0};
        tbl[15] = '{0, 0, 0, 0, 5'h00, 32'h0,       6'b000000, 0, 32'h0};
        tbl[16] = '{1, 1, 0, 1, 5'h0E, 32'hABCD,    6'b000000, 1, 32'h0000_ABCD};
        tbl[17] = '{1, 0, 0, 0, 5'h00, 32'h0,       6'b000000, 0, 32'h0};

        // ---- table-driven vectors ----
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, tbl[i].sid, tbl[i].start, tbl[i].done, tbl[i].ev,
                  tbl[i].et, tbl[i].epc, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.xstall", i), 32'(stall_en), 32'(tbl[i].x_stall));
            chk($sformatf("tbl%0d.xflush", i), 32'(flush), 32'(tbl[i].x_flush));
            chk($sformatf("tbl%0d.xpc", i), new_pc, tbl[i].x_pc);
        end
        idle("tbl_end");
        chk("tbl_cnt", 32'(stall_cycles), 32'd7);

        // ---- divide: done 10 cycles after start ----
        do_reset();
        chk("rst_stall", 32'(stall_en), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0, "div_start");
        chk("div_s0", 32'(stall_en), 32'b001111);
        for (int k = 1; k < 10; k++) begin
            idle("div_wait");
            chk("div_w", 32'(stall_en), 32'b001111);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h0, 32'h0, "div_done");
        chk("div_done", 32'(stall_en), 32'd0);
        idle("div_after");
        chk("div_cnt", 32'(stall_cycles), 32'd10);
        chk("div_idle", 32'(stall_en), 32'd0);

        // ---- watchdog ----
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0, "wd_start");
        for (int k = 1; k < T; k++) begin
            idle("wd_wait");
            chk("wd_w", 32'(stall_en), 32'b001111);
        end
        idle("wd_fire");
        chk("wd_fire_stall", 32'(stall_en), 32'd0);
        chk("wd_fire_tout", 32'(mc_timeout), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, "wd_after");
        chk("wd_tout", 32'(mc_timeout), 32'd1);
        chk("wd_idle_sid", 32'(stall_en), 32'b000111);
        chk("wd_cnt", 32'(stall_cycles), 32'd64);
        for (int k = 0; k < 5; k++) idle("wd_sticky");
        chk("wd_sticky", 32'(mc_timeout), 32'd1);
        do_reset();
        idle("wd_post_rst");
        chk("wd_rst_tout", 32'(mc_timeout), 32'd0);
        chk("wd_rst_cnt", 32'(stall_cycles), 32'd0);

        // ---- saturation of the 4-bit counter ----
        do_reset();
        for (int k = 0; k < 20; k++)
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, "sat_sid");
        idle("sat_end");
        chk("sat_cnt4", 32'(stall_cycles4), 32'd15);
        chk("sat_cnt16", 32'(stall_cycles), 32'd20);

        // ---- randomized against the model ----
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            logic r, s, st, d, e;
            logic [4:0] t;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 99) < 30);
            st = ($urandom_range(0, 99) < 10);
            d  = ($urandom_range(0, 99) < 8);
            e  = ($urandom_range(0, 99) < 3);
            t  = ($urandom_range(0, 1) == 1) ? 5'h0E : 5'($urandom_range(0, 31));
            cycle(r, s, st, d, e, t, $urandom, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline controller for the 5-stage core. It generates the per-stage stall vector consumed by every inter-stage buffer (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It also sequences multi-cycle EX operations (div/madd) with a watchdog, and issues the exception/ERET flush with the redirect PC. It sits beside the datapath and takes stall requests from ID and EX and exception info from MEM/CP0.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect PC for all exceptions other than ERET
ERET_CODE, 5'h0E, excp_type value meaning ERET (redirect to cp0_epc)
MC_TIMEOUT, 64, max cycles in MC_WAIT before the watchdog fires
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
stallreq_id  input  1  ID load-use hazard request
ex_mc_start  input  1  EX begins a multi-cycle op (1-cycle pulse)
ex_mc_done  input  1  EX multi-cycle result ready (1-cycle pulse)
excp_valid  input  1  MEM-stage exception/ERET committed this cycle
excp_type  input  5  exception code
cp0_epc  input  32  EPC from CP0
stall_en  output  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold
flush  output  1  clear all pipeline buffers, load new_pc
new_pc  output  32  redirect target, valid when flush=1
mc_timeout  output  1  sticky watchdog error
stall_cycles  output  CNT_W  saturating count of cycles with stall_en[0]=1

Behaviour:
- Reset: state IDLE, wd_cnt=0, stall_cycles=0, mc_timeout=0. stall_en=0, flush=0, new_pc=0 during reset. Reset mid-MC_WAIT aborts with no flush.
- stall_en, flush and new_pc are combinational from state and inputs (same-cycle effect). state, wd_cnt, mc_timeout and stall_cycles are registered.
- Stall encodings: ID stall = 6'b000111 (a buffer sees bit k=1 and bit k+1=0 and inserts a bubble downstream). EX stall = 6'b001111.
- Priority: excp_valid > MC stall > stallreq_id.
- States:
  - IDLE
    - excp_valid: flush=1, stall_en=0; go to REFILL.
    - else ex_mc_start: stall_en=001111; go to MC_WAIT with wd_cnt=1.
    - else stallreq_id: stall_en=000111; stay in IDLE.
    - else stall_en=0.
  - MC_WAIT
    - excp_valid: flush=1; go to REFILL (abort op).
    - else ex_mc_done: stall_en = stallreq_id ? 000111 : 0; go to IDLE.
    - else wd_cnt==MC_TIMEOUT: mc_timeout<=1, stall_en=0; go to IDLE.
    - else stall_en=001111, wd_cnt++.
  - REFILL (exactly 1 cycle): stallreq_id and ex_mc_start are ignored (they come from flushed instructions). stall_en=0. excp_valid is ignored. Go to IDLE.
- new_pc: excp_type==ERET_CODE ? cp0_epc : EXC_VECTOR. Outside flush it is 0.
- ex_mc_start and ex_mc_done in the same IDLE cycle: treated as a 1-cycle op, with no stall and state stays IDLE.
- stall_cycles increments each cycle stall_en[0]=1 and saturates at all-ones (no wrap).
- mc_timeout clears only on reset.

Decomposition:
- Shared package (cpu_defs): stall vector constants STALL_NONE/STALL_ID/STALL_EX, the state enum (IDLE, MC_WAIT, REFILL), and exception codes including ERET_CODE.
- One natural sub-module: sat_counter (CNT_W-wide saturating counter with enable), used for stall_cycles.

Test Plan:
- Load-use: stallreq_id=1 for 1 cycle in IDLE -> stall_en=000111 that cycle, 0 next cycle; stall_cycles 0->1.
- Divide: ex_mc_start, then ex_mc_done 10 cycles later -> stall_en=001111 for cycles 0..9 and 0 on the done cycle; state back to IDLE; stall_cycles=10.
- ERET during MC_WAIT: excp_valid=1, excp_type=0x0E, cp0_epc=0x0000_1234 -> flush=1, new_pc=0x0000_1234, stall_en=0; next cycle REFILL with stallreq_id=1 -> stall_en=0.
- Exception in IDLE: excp_valid=1, excp_type=0x0C -> new_pc=0x0000_0020, flush=1 for exactly 1 cycle.
- Watchdog: ex_mc_start with no done for 64 cycles -> mc_timeout=1 (sticky), stall_en=0, IDLE; reset -> mc_timeout=0, stall_cycles=0.
- Saturation: CNT_W=4, stallreq_id held for 20 cycles -> stall_cycles=15.
